// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: FSM state encoding, table sizes and key-byte selection.
// The key-search datapath imports this too, so keep the state encoding stable.
package rc4_pkg;

  localparam int S_SIZE    = 256;
  localparam int KEY_BYTES = 3;

  typedef enum logic [4:0] {
    IDLE,
    INIT,
    KSA_RI,
    KSA_WI,
    KSA_RJ,
    KSA_WJ,
    KSA_SWI,
    KSA_SWJ,
    PR_RI,
    PR_WI,
    PR_RJ,
    PR_WJ,
    PR_SWI,
    PR_SWJ,
    PR_RF,
    PR_WF,
    PR_WC,
    DONE
  } state_t;

  // Byte 0 of the key schedule is the most significant key byte.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [7:0] idx);
    logic [7:0] b;
    case (idx % 8'(KEY_BYTES))
      8'd0:    b = key[23:16];
      8'd1:    b = key[15:8];
      default: b = key[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rc4_encryptor.sv
// RC4 encryption engine: builds S in an external 256x8 RAM, then XORs the keystream
// with a plaintext ROM and writes the ciphertext RAM. All memories have 1-cycle reads.
module rc4_encryptor
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int C_AW    = $clog2(MSG_LEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [23:0]     secret_key,
  output logic            busy,
  output logic            done,
  output logic [7:0]      s_addr,
  output logic [7:0]      s_wdata,
  output logic            s_wren,
  input  logic [7:0]      s_rdata,
  output logic [C_AW-1:0] p_addr,
  input  logic [7:0]      p_rdata,
  output logic [C_AW-1:0] c_addr,
  output logic [7:0]      c_wdata,
  output logic            c_wren
);

  localparam logic [7:0] LAST_BYTE = 8'(MSG_LEN - 1);
  localparam logic [7:0] LAST_S    = 8'(S_SIZE - 1);

  state_t      state;
  logic [7:0]  i, j, k, si_q, sj_q;
  logic [23:0] key_q;
  logic [7:0]  i_next, j_ksa, j_prga;

  assign i_next = i + 8'd1;
  assign j_ksa  = j + s_rdata + key_byte(key_q, i);
  assign j_prga = j + s_rdata;

  // Every R* state drives an address, the following W* state waits for the RAM,
  // and the state after that consumes s_rdata. Writes are issued one state ahead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_addr  <= 8'd0;
      s_wdata <= 8'd0;
      s_wren  <= 1'b0;
      p_addr  <= '0;
      c_addr  <= '0;
      c_wdata <= 8'd0;
      c_wren  <= 1'b0;
      i       <= 8'd0;
      j       <= 8'd0;
      k       <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      key_q   <= 24'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_q <= secret_key;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= 8'd0;
            busy  <= 1'b1;
            state <= INIT;
          end
        end
        INIT: begin
          s_addr  <= i;
          s_wdata <= i;
          s_wren  <= 1'b1;
          i       <= i_next;
          if (i == LAST_S) state <= KSA_RI;
        end
        KSA_RI: begin
          s_wren <= 1'b0;
          s_addr <= i;
          state  <= KSA_WI;
        end
        KSA_WI: state <= KSA_RJ;
        KSA_RJ: begin
          si_q   <= s_rdata;
          j      <= j_ksa;
          s_addr <= j_ksa;
          state  <= KSA_WJ;
        end
        KSA_WJ: state <= KSA_SWI;
        KSA_SWI: begin
          sj_q    <= s_rdata;
          s_addr  <= i;
          s_wdata <= s_rdata;
          s_wren  <= 1'b1;
          state   <= KSA_SWJ;
        end
        KSA_SWJ: begin
          s_addr  <= j;
          s_wdata <= si_q;
          i       <= i_next;
          if (i == LAST_S) begin
            j     <= 8'd0;
            state <= PR_RI;
          end else begin
            state <= KSA_RI;
          end
        end
        PR_RI: begin
          s_wren <= 1'b0;
          c_wren <= 1'b0;
          i      <= i_next;
          s_addr <= i_next;
          state  <= PR_WI;
        end
        PR_WI: state <= PR_RJ;
        PR_RJ: begin
          si_q   <= s_rdata;
          j      <= j_prga;
          s_addr <= j_prga;
          state  <= PR_WJ;
        end
        PR_WJ: state <= PR_SWI;
        PR_SWI: begin
          sj_q    <= s_rdata;
          s_addr  <= i;
          s_wdata <= s_rdata;
          s_wren  <= 1'b1;
          state   <= PR_SWJ;
        end
        PR_SWJ: begin
          s_addr  <= j;
          s_wdata <= si_q;
          state   <= PR_RF;
        end
        // The S[j] write lands while the keystream address is being presented.
        PR_RF: begin
          s_wren <= 1'b0;
          s_addr <= si_q + sj_q;
          p_addr <= k[C_AW-1:0];
          state  <= PR_WF;
        end
        PR_WF: state <= PR_WC;
        PR_WC: begin
          c_addr  <= k[C_AW-1:0];
          c_wdata <= s_rdata ^ p_rdata;
          c_wren  <= 1'b1;
          k       <= k + 8'd1;
          if (k == LAST_BYTE) state <= DONE;
          else                state <= PR_RI;
        end
        DONE: begin
          c_wren <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_encryptor.sv
// Bench for rc4_encryptor: three instances (9, 32, 256-byte messages) with behavioural
// memories, checked against a plain software RC4 model of the expected ciphertext.
module tb_rc4_encryptor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  start_v;
  logic [23:0] secret_key;
  logic        scramble;

  always #5 clk = ~clk;

  logic       busy0, done0, s_wren0, c_wren0;
  logic [7:0] s_addr0, s_wdata0, s_rdata0, p_rdata0, c_wdata0;
  logic [3:0] p_addr0, c_addr0;
  logic       busy1, done1, s_wren1, c_wren1;
  logic [7:0] s_addr1, s_wdata1, s_rdata1, p_rdata1, c_wdata1;
  logic [4:0] p_addr1, c_addr1;
  logic       busy2, done2, s_wren2, c_wren2;
  logic [7:0] s_addr2, s_wdata2, s_rdata2, p_rdata2, c_wdata2;
  logic [7:0] p_addr2, c_addr2;

  logic [7:0] s_mem0 [256];
  logic [7:0] s_mem1 [256];
  logic [7:0] s_mem2 [256];
  logic [7:0] plain_buf [256];

  rc4_encryptor #(.MSG_LEN(9)) u_enc9 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .secret_key(secret_key),
    .busy(busy0), .done(done0), .s_addr(s_addr0), .s_wdata(s_wdata0), .s_wren(s_wren0),
    .s_rdata(s_rdata0), .p_addr(p_addr0), .p_rdata(p_rdata0), .c_addr(c_addr0),
    .c_wdata(c_wdata0), .c_wren(c_wren0)
  );

  rc4_encryptor #(.MSG_LEN(32)) u_enc32 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .secret_key(secret_key),
    .busy(busy1), .done(done1), .s_addr(s_addr1), .s_wdata(s_wdata1), .s_wren(s_wren1),
    .s_rdata(s_rdata1), .p_addr(p_addr1), .p_rdata(p_rdata1), .c_addr(c_addr1),
    .c_wdata(c_wdata1), .c_wren(c_wren1)
  );

  rc4_encryptor #(.MSG_LEN(256)) u_enc256 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .secret_key(secret_key),
    .busy(busy2), .done(done2), .s_addr(s_addr2), .s_wdata(s_wdata2), .s_wren(s_wren2),
    .s_rdata(s_rdata2), .p_addr(p_addr2), .p_rdata(p_rdata2), .c_addr(c_addr2),
    .c_wdata(c_wdata2), .c_wren(c_wren2)
  );

  // Synchronous RAM/ROM models; scramble preloads S with a non-identity pattern.
  always @(posedge clk) begin
    if (scramble) begin
      for (int n = 0; n < 256; n++) begin
        s_mem0[n] <= 8'(n * 7 + 3);
        s_mem1[n] <= 8'(n * 7 + 3);
        s_mem2[n] <= 8'(n * 7 + 3);
      end
    end else begin
      if (s_wren0) s_mem0[s_addr0] <= s_wdata0;
      if (s_wren1) s_mem1[s_addr1] <= s_wdata1;
      if (s_wren2) s_mem2[s_addr2] <= s_wdata2;
    end
    s_rdata0 <= s_mem0[s_addr0];
    s_rdata1 <= s_mem1[s_addr1];
    s_rdata2 <= s_mem2[s_addr2];
    p_rdata0 <= plain_buf[{4'd0, p_addr0}];
    p_rdata1 <= plain_buf[{3'd0, p_addr1}];
    p_rdata2 <= plain_buf[p_addr2];
  end

  int         sel;
  logic       busy_m, done_m, s_wren_m, c_wren_m;
  logic [7:0] s_addr_m, s_wdata_m, p_addr_m, c_addr_m, c_wdata_m;

  always_comb begin
    busy_m = busy1; done_m = done1; s_wren_m = s_wren1; c_wren_m = c_wren1;
    s_addr_m = s_addr1; s_wdata_m = s_wdata1; c_wdata_m = c_wdata1;
    p_addr_m = {3'd0, p_addr1}; c_addr_m = {3'd0, c_addr1};
    case (sel)
      0: begin
        busy_m = busy0; done_m = done0; s_wren_m = s_wren0; c_wren_m = c_wren0;
        s_addr_m = s_addr0; s_wdata_m = s_wdata0; c_wdata_m = c_wdata0;
        p_addr_m = {4'd0, p_addr0}; c_addr_m = {4'd0, c_addr0};
      end
      2: begin
        busy_m = busy2; done_m = done2; s_wren_m = s_wren2; c_wren_m = c_wren2;
        s_addr_m = s_addr2; s_wdata_m = s_wdata2; c_wdata_m = c_wdata2;
        p_addr_m = p_addr2; c_addr_m = c_addr2;
      end
      default: ;
    endcase
  end

  int         checks_total = 0;
  int         checks_passed = 0;
  logic [7:0] exp_c [256];
  logic [7:0] got_c [256];
  int         exp_len = 0;
  int         exp_idx = 0;
  int         done_cnt = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Textbook RC4 over plain integer arrays.
  task automatic model_encrypt(input logic [23:0] key, input int len);
    int s [256];
    int ii, jj, t, kb;
    for (int n = 0; n < 256; n++) s[n] = n;
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      kb = int'((key >> (8 * (2 - n % 3))) & 24'hFF);
      jj = (jj + s[n] + kb) % 256;
      t = s[n]; s[n] = s[jj]; s[jj] = t;
    end
    ii = 0;
    jj = 0;
    for (int n = 0; n < len; n++) begin
      ii = (ii + 1) % 256;
      jj = (jj + s[ii]) % 256;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      exp_c[n] = 8'(s[(s[ii] + s[jj]) % 256]) ^ plain_buf[n];
    end
    exp_len = len;
    exp_idx = 0;
  endtask

  // Every ciphertext write must land in order, at the next index, with the model byte.
  always @(negedge clk) begin
    if (reset_n) begin
      if (c_wren_m) begin
        if (exp_idx < exp_len) begin
          checkOutput("c_addr", int'(c_addr_m), exp_idx);
          checkOutput("c_wdata", int'(c_wdata_m), int'(exp_c[exp_idx]));
          got_c[exp_idx] = c_wdata_m;
          exp_idx++;
        end else begin
          checkOutput("c_write_count", exp_idx + 1, exp_len);
        end
      end
      if (done_m) begin
        done_cnt++;
        checkOutput("busy_low_at_done", int'(busy_m), 0);
      end
    end
  end

  task automatic applyStimulus(input int which, input logic [23:0] key, input int len,
                               input int inject_at, input int abort_at, input bit init_check);
    int cyc;
    bit seen;
    int lat;
    lat = 1 + 256 + 1536 + 9 * len;
    sel = which;
    done_cnt = 0;
    model_encrypt(key, len);
    @(negedge clk);
    secret_key = key;
    start_v[which] = 1'b1;
    @(posedge clk);
    #1;
    start_v = 3'b000;
    secret_key = ~key;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < lat + 20) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done_m) seen = 1'b1;
      if (cyc == inject_at) begin
        secret_key = key ^ 24'h5A5A5A;
        start_v[which] = 1'b1;
      end else begin
        start_v = 3'b000;
      end
      if (init_check && cyc == 258)
        for (int n = 0; n < 256; n++) checkOutput("init_s_identity", int'(s_mem1[n]), n);
      if (cyc == abort_at) begin
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_busy", int'(busy_m), 0);
        checkOutput("reset_done", int'(done_m), 0);
        checkOutput("reset_s_wren", int'(s_wren_m), 0);
        checkOutput("reset_c_wren", int'(c_wren_m), 0);
        checkOutput("reset_s_addr", int'(s_addr_m), 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        return;
      end
    end
    checkOutput("done_latency", seen ? cyc : -1, lat);
    checkOutput("bytes_written", exp_idx, len);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("done_pulses", done_cnt, 1);
  endtask

  logic [71:0] kat_plain;
  logic [7:0]  kat_c [9];
  logic [7:0]  orig [32];
  logic [23:0] rkey;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start_v = 3'b000;
    secret_key = 24'd0;
    sel = 1;
    scramble = 1'b1;
    for (int n = 0; n < 256; n++) plain_buf[n] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    scramble = 1'b0;
    for (int w = 0; w < 3; w++) begin
      sel = w;
      #1;
      checkOutput("rst_busy", int'(busy_m), 0);
      checkOutput("rst_done", int'(done_m), 0);
      checkOutput("rst_s_wren", int'(s_wren_m), 0);
      checkOutput("rst_c_wren", int'(c_wren_m), 0);
      checkOutput("rst_s_addr", int'(s_addr_m), 0);
      checkOutput("rst_s_wdata", int'(s_wdata_m), 0);
      checkOutput("rst_p_addr", int'(p_addr_m), 0);
      checkOutput("rst_c_addr", int'(c_addr_m), 0);
      checkOutput("rst_c_wdata", int'(c_wdata_m), 0);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] known-answer: key \"Key\", plaintext \"Plaintext\"");
    kat_plain = 72'h506C61696E74657874;
    kat_c = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int n = 0; n < 9; n++) plain_buf[n] = kat_plain[71 - 8 * n -: 8];
    applyStimulus(0, 24'h4B6579, 9, -1, -1, 1'b0);
    for (int n = 0; n < 9; n++) checkOutput("kat_model", int'(exp_c[n]), int'(kat_c[n]));
    for (int n = 0; n < 9; n++) checkOutput("kat_dut", int'(got_c[n]), int'(kat_c[n]));

    $display("[TB] round trip with key 0x000249 and INIT identity check");
    for (int n = 0; n < 32; n++) begin
      plain_buf[n] = 8'($urandom_range(0, 255));
      orig[n] = plain_buf[n];
    end
    applyStimulus(1, 24'h000249, 32, -1, -1, 1'b1);
    for (int n = 0; n < 32; n++) plain_buf[n] = got_c[n];
    applyStimulus(1, 24'h000249, 32, -1, -1, 1'b0);
    for (int n = 0; n < 32; n++) checkOutput("round_trip", int'(got_c[n]), int'(orig[n]));

    $display("[TB] reset asserted mid-KSA, then full rerun");
    rkey = 24'($urandom);
    for (int n = 0; n < 32; n++) plain_buf[n] = 8'($urandom_range(0, 255));
    applyStimulus(1, rkey, 32, -1, 700, 1'b0);
    repeat (2) @(posedge clk);
    applyStimulus(1, rkey, 32, -1, -1, 1'b0);

    $display("[TB] start with a different key while busy");
    rkey = 24'($urandom);
    applyStimulus(1, rkey, 32, 1000, -1, 1'b0);

    $display("[TB] all-zero key, 256 zero bytes");
    for (int n = 0; n < 256; n++) plain_buf[n] = 8'd0;
    applyStimulus(2, 24'h000000, 256, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
